// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: default geometry,
// slot FSM encodings and a counter-width helper.
package seg7_pkg;

  localparam int DEF_DIGITS   = 4;
  localparam int DEF_TICK_DIV = 1000;
  localparam int DEF_GUARD    = 2;

  localparam logic [0:0] ST_GUARD = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  // Width needed to count 0..n-1, never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot timer: cycle counter within a slot, GUARD/DRIVE FSM and digit index.
// Exposes next-state views so the controller can register outputs cycle-aligned.
module seg7_slot_timer
  import seg7_pkg::*;
#(
  parameter int DIGITS   = DEF_DIGITS,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int GUARD    = DEF_GUARD,
  localparam int CW      = cnt_w(TICK_DIV),
  localparam int IW      = cnt_w(DIGITS)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  output logic [IW-1:0] o_idx_next,
  output logic          o_guard_next,
  output logic          o_last_next,
  output logic          o_wrap
);

  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic [0:0]    r_state;

  logic          w_slot_end;
  logic [CW-1:0] w_cnt_next;
  logic [IW-1:0] w_idx_next;
  logic [0:0]    w_state_next;

  assign w_slot_end = (r_cnt == CW'(TICK_DIV - 1));
  assign w_cnt_next = w_slot_end ? '0 : r_cnt + 1'b1;
  assign w_idx_next = !w_slot_end ? r_idx :
                      (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_GUARD: if (r_cnt == CW'(GUARD - 1)) w_state_next = ST_DRIVE;
      ST_DRIVE: if (w_slot_end)              w_state_next = ST_GUARD;
      default:                               w_state_next = ST_GUARD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_state <= ST_GUARD;
    end else begin
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_state <= w_state_next;
    end
  end

  assign o_idx_next   = w_idx_next;
  assign o_guard_next = (w_state_next == ST_GUARD);
  assign o_last_next  = (w_cnt_next == CW'(TICK_DIV - 1)) && (w_idx_next == IW'(DIGITS - 1));
  assign o_wrap       = w_slot_end && (r_idx == IW'(DIGITS - 1));

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered frame (pending/active),
// valid/ready load handshake and registered decoder/anode outputs.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS   = DEF_DIGITS,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int GUARD    = DEF_GUARD
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load_valid,
  output logic                  o_load_ready,
  input  logic [4*DIGITS-1:0]   i_load_data,
  input  logic [DIGITS-1:0]     i_load_mode,
  input  logic [DIGITS-1:0]     i_load_blank,
  output logic                  o_seg_mode,
  output logic [3:0]            o_seg_data,
  output logic [DIGITS-1:0]     o_an_n,
  output logic                  o_frame_done
);

  localparam int IW = cnt_w(DIGITS);

  logic [IW-1:0]         w_idx_next;
  logic                  w_guard_next;
  logic                  w_last_next;
  logic                  w_wrap;

  logic                  r_pend_full;
  logic [4*DIGITS-1:0]   r_pend_data;
  logic [DIGITS-1:0]     r_pend_mode;
  logic [DIGITS-1:0]     r_pend_blank;
  logic [4*DIGITS-1:0]   r_act_data;
  logic [DIGITS-1:0]     r_act_mode;
  logic [DIGITS-1:0]     r_act_blank;

  logic                  w_fire;
  logic                  w_swap;
  logic [4*DIGITS-1:0]   w_data_next;
  logic [DIGITS-1:0]     w_mode_next;
  logic [DIGITS-1:0]     w_blank_next;
  logic [3:0]            w_nib [DIGITS];
  logic [DIGITS-1:0]     w_an_next;

  seg7_slot_timer #(
    .DIGITS   (DIGITS),
    .TICK_DIV (TICK_DIV),
    .GUARD    (GUARD)
  ) u_timer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .o_idx_next   (w_idx_next),
    .o_guard_next (w_guard_next),
    .o_last_next  (w_last_next),
    .o_wrap       (w_wrap)
  );

  assign o_load_ready = ~r_pend_full;
  assign w_fire       = i_load_valid & ~r_pend_full;
  // The swap lands on the edge into the first cycle of slot 0, so that whole slot shows the new frame.
  assign w_swap       = w_wrap & r_pend_full;

  assign w_data_next  = w_swap ? r_pend_data  : r_act_data;
  assign w_mode_next  = w_swap ? r_pend_mode  : r_act_mode;
  assign w_blank_next = w_swap ? r_pend_blank : r_act_blank;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign w_nib[gi]     = w_data_next[4*gi +: 4];
    assign w_an_next[gi] = ~((w_idx_next == IW'(gi)) & ~w_guard_next & ~w_blank_next[gi]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_full  <= 1'b0;
      r_pend_data  <= '0;
      r_pend_mode  <= '0;
      r_pend_blank <= '0;
    end else if (w_fire) begin
      r_pend_full  <= 1'b1;
      r_pend_data  <= i_load_data;
      r_pend_mode  <= i_load_mode;
      r_pend_blank <= i_load_blank;
    end else if (w_swap) begin
      r_pend_full  <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_act_data   <= '0;
      r_act_mode   <= '0;
      r_act_blank  <= '1;
      o_seg_data   <= 4'h0;
      o_seg_mode   <= 1'b0;
      o_an_n       <= '1;
      o_frame_done <= 1'b0;
    end else begin
      r_act_data   <= w_data_next;
      r_act_mode   <= w_mode_next;
      r_act_blank  <= w_blank_next;
      o_seg_data   <= w_nib[w_idx_next];
      o_seg_mode   <= w_mode_next[w_idx_next];
      o_an_n       <= w_an_next;
      o_frame_done <= w_last_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed, table-driven bench for seg7_scan_ctrl (4 digits, 8-cycle slots, 2-cycle guard).
module tb_seg7_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  load_mode;
  logic [3:0]  load_blank;
  logic        seg_mode;
  logic [3:0]  seg_data;
  logic [3:0]  an_n;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  seg7_scan_ctrl #(
    .DIGITS   (4),
    .TICK_DIV (8),
    .GUARD    (2)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_load_valid (load_valid),
    .o_load_ready (load_ready),
    .i_load_data  (load_data),
    .i_load_mode  (load_mode),
    .i_load_blank (load_blank),
    .o_seg_mode   (seg_mode),
    .o_seg_data   (seg_data),
    .o_an_n       (an_n),
    .o_frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        vld;
    logic [15:0] dat;
    logic [3:0]  mode;
    logic [3:0]  blank;
    logic [3:0]  e_an;
    logic [3:0]  e_data;
    logic        e_mode;
    logic        e_fd;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int c, logic v, logic [15:0] d, logic [3:0] m, logic [3:0] b,
                              logic [3:0] an, logic [3:0] sd, logic sm, logic fd, logic rdy);
    vec_t r;
    r.cyc = c; r.vld = v; r.dat = d; r.mode = m; r.blank = b;
    r.e_an = an; r.e_data = sd; r.e_mode = sm; r.e_fd = fd; r.e_rdy = rdy;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_outs(input logic [3:0] an, input logic [3:0] sd, input logic sm,
                          input logic fd, input logic rdy);
    chk("an_n", {28'd0, an_n}, {28'd0, an});
    chk("seg_data", {28'd0, seg_data}, {28'd0, sd});
    chk("seg_mode", {31'd0, seg_mode}, {31'd0, sm});
    chk("frame_done", {31'd0, frame_done}, {31'd0, fd});
    chk("load_ready", {31'd0, load_ready}, {31'd0, rdy});
    $display("cyc %0d an_n=%h seg_data=%h seg_mode=%b frame_done=%b load_ready=%b",
             cyc, an_n, seg_data, seg_mode, frame_done, load_ready);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Frame f, slot s, cycle k -> f*32 + s*8 + k
    vecs.push_back(mk(  0, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 4'h0, 0, 0, 1));
    vecs.push_back(mk(  2, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 4'h0, 0, 0, 1));
    vecs.push_back(mk( 30, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 4'h0, 0, 0, 1));
    vecs.push_back(mk( 31, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 4'h0, 0, 1, 1));
    vecs.push_back(mk( 33, 1, 16'h9F30, 4'h0, 4'h0, 4'hF, 4'h0, 0, 0, 1));
    vecs.push_back(mk( 34, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 4'h0, 0, 0, 0));
    vecs.push_back(mk( 63, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 4'h0, 0, 1, 0));
    vecs.push_back(mk( 64, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 4'h0, 0, 0, 1));
    vecs.push_back(mk( 65, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 4'h0, 0, 0, 1));
    vecs.push_back(mk( 66, 0, 16'h0000, 4'h0, 4'h0, 4'hE, 4'h0, 0, 0, 1));
    vecs.push_back(mk( 71, 0, 16'h0000, 4'h0, 4'h0, 4'hE, 4'h0, 0, 0, 1));
    vecs.push_back(mk( 72, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 4'h3, 0, 0, 1));
    vecs.push_back(mk( 74, 0, 16'h0000, 4'h0, 4'h0, 4'hD, 4'h3, 0, 0, 1));
    vecs.push_back(mk( 80, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 4'hF, 0, 0, 1));
    vecs.push_back(mk( 82, 0, 16'h0000, 4'h0, 4'h0, 4'hB, 4'hF, 0, 0, 1));
    vecs.push_back(mk( 90, 0, 16'h0000, 4'h0, 4'h0, 4'h7, 4'h9, 0, 0, 1));
    vecs.push_back(mk( 95, 0, 16'h0000, 4'h0, 4'h0, 4'h7, 4'h9, 0, 1, 1));
    vecs.push_back(mk( 96, 1, 16'h000F, 4'h1, 4'h0, 4'hF, 4'h0, 0, 0, 1));
    vecs.push_back(mk( 97, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 4'h0, 0, 0, 0));
    vecs.push_back(mk( 98, 0, 16'h0000, 4'h0, 4'h0, 4'hE, 4'h0, 0, 0, 0));
    vecs.push_back(mk(127, 0, 16'h0000, 4'h0, 4'h0, 4'h7, 4'h9, 0, 1, 0));
    vecs.push_back(mk(128, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 4'hF, 1, 0, 1));
    vecs.push_back(mk(130, 0, 16'h0000, 4'h0, 4'h0, 4'hE, 4'hF, 1, 0, 1));
    vecs.push_back(mk(136, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 4'h0, 0, 0, 1));
    vecs.push_back(mk(138, 0, 16'h0000, 4'h0, 4'h0, 4'hD, 4'h0, 0, 0, 1));
    vecs.push_back(mk(140, 1, 16'h1234, 4'h0, 4'h0, 4'hD, 4'h0, 0, 0, 1));
    vecs.push_back(mk(141, 1, 16'h5678, 4'h0, 4'h0, 4'hD, 4'h0, 0, 0, 0));
    vecs.push_back(mk(159, 1, 16'h5678, 4'h0, 4'h0, 4'h7, 4'h0, 0, 1, 0));
    vecs.push_back(mk(160, 1, 16'h5678, 4'h0, 4'h0, 4'hF, 4'h4, 0, 0, 1));
    vecs.push_back(mk(161, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 4'h4, 0, 0, 0));
    vecs.push_back(mk(162, 0, 16'h0000, 4'h0, 4'h0, 4'hE, 4'h4, 0, 0, 0));
    vecs.push_back(mk(186, 0, 16'h0000, 4'h0, 4'h0, 4'h7, 4'h1, 0, 0, 0));
    vecs.push_back(mk(192, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 4'h8, 0, 0, 1));
    vecs.push_back(mk(194, 0, 16'h0000, 4'h0, 4'h0, 4'hE, 4'h8, 0, 0, 1));
    vecs.push_back(mk(200, 1, 16'hABCD, 4'h0, 4'h4, 4'hF, 4'h7, 0, 0, 1));
    vecs.push_back(mk(201, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 4'h7, 0, 0, 0));
    vecs.push_back(mk(218, 0, 16'h0000, 4'h0, 4'h0, 4'h7, 4'h5, 0, 0, 0));
    vecs.push_back(mk(224, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 4'hD, 0, 0, 1));
    vecs.push_back(mk(226, 0, 16'h0000, 4'h0, 4'h0, 4'hE, 4'hD, 0, 0, 1));
    vecs.push_back(mk(234, 0, 16'h0000, 4'h0, 4'h0, 4'hD, 4'hC, 0, 0, 1));
    vecs.push_back(mk(240, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 4'hB, 0, 0, 1));
    vecs.push_back(mk(242, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 4'hB, 0, 0, 1));
    vecs.push_back(mk(247, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 4'hB, 0, 0, 1));
    vecs.push_back(mk(250, 0, 16'h0000, 4'h0, 4'h0, 4'h7, 4'hA, 0, 0, 1));
    vecs.push_back(mk(258, 1, 16'h7777, 4'hF, 4'h0, 4'hE, 4'hD, 0, 0, 1));
    vecs.push_back(mk(259, 0, 16'h0000, 4'h0, 4'h0, 4'hE, 4'hD, 0, 0, 0));
    vecs.push_back(mk(269, 0, 16'h0000, 4'h0, 4'h0, 4'hD, 4'hC, 0, 0, 0));

    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0;
    load_mode  = 4'h0;
    load_blank = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;

    foreach (vecs[i]) begin
      goto(vecs[i].cyc);
      chk_outs(vecs[i].e_an, vecs[i].e_data, vecs[i].e_mode, vecs[i].e_fd, vecs[i].e_rdy);
      load_valid = vecs[i].vld;
      load_data  = vecs[i].dat;
      load_mode  = vecs[i].mode;
      load_blank = vecs[i].blank;
    end

    // Reset mid-DRIVE (frame 8, cycle 13) with a load still pending.
    rst_n = 1'b0;
    #1;
    chk_outs(4'hF, 4'h0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    chk_outs(4'hF, 4'h0, 0, 0, 1);
    rst_n = 1'b1;
    cyc   = 0;
    chk_outs(4'hF, 4'h0, 0, 0, 1);
    goto(2);
    chk_outs(4'hF, 4'h0, 0, 0, 1);
    goto(31);
    chk_outs(4'hF, 4'h0, 0, 1, 1);
    // Discarded pending load must not appear at the next boundary.
    goto(34);
    chk_outs(4'hF, 4'h0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It holds one frame of digit nibbles and per-digit mode and blank bits, and steps through the digits on a fixed slot period. Each slot it drives one 4-bit value plus MODE to the shared `bin_7seg_disp` decoder and enables that digit's anode after a ghosting guard interval. It sits between the register/control logic that produces values and the single combinational decoder feeding the segment pins.

## Interface
- `DIGITS`, 4, number of multiplexed digits (≥2); all per-digit widths derive from it
- `TICK_DIV`, 1000, clock cycles per digit slot (> GUARD)
- `GUARD`, 2, cycles at slot start with all anodes off (≥1)
- `clk`  in  1  single system clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `load_valid`  in  1  new frame offered
- `load_ready`  out  1  pending buffer empty; load accepted when valid&ready
- `load_data`  in  4*DIGITS  nibble i = bits [4i+3:4i], digit 0 rightmost
- `load_mode`  in  DIGITS  per-digit MODE (1 = signed −8..7, 0 = unsigned 0..15 hex)
- `load_blank`  in  DIGITS  per-digit blank (1 = anode never enabled)
- `seg_mode`  out  1  MODE to decoder
- `seg_data`  out  4  DATA to decoder
- `an_n`  out  DIGITS  active-low anode enables, one-hot-low or all-high
- `frame_done`  out  1  one-cycle pulse, last cycle of final slot

## Operation
- Two register sets: pending (data/mode/blank + full flag) and active.
- Handshake: `load_ready = ~pending_full`. On valid&ready capture inputs into pending, set full. Inputs ignored when ready=0; `load_valid` may drop without acceptance.
- Frame boundary = first cycle of digit 0 slot. There, if pending_full: active ← pending, full cleared (ready rises next cycle). Acceptance in the boundary cycle itself lands in pending, applied next frame.
- FSM per slot: GUARD (slot counter 0..GUARD−1, `an_n` all 1) → DRIVE (GUARD..TICK_DIV−1, `an_n[idx]`=0 unless active blank[idx]) → GUARD of idx+1. Index wraps DIGITS−1 → 0.
- `seg_data`/`seg_mode` take active nibble/mode of idx on first GUARD cycle and hold for the slot, so decoder settles before anode enable.
- No arbitrary stop state: scanning is free-running from reset.

## Timing
- Reset values: `an_n` all 1, `seg_data` 0, `seg_mode` 0, `load_ready` 1, `frame_done` 0, idx 0, slot counter 0, pending empty, active data 0, active mode 0, active blank all 1 (dark until first load).
- First cycle after reset release is cycle 0 of slot 0 (a frame boundary).
- All outputs registered; `load_ready` combinational from full flag only.
- Slot = TICK_DIV cycles; frame = DIGITS·TICK_DIV cycles; anode low exactly TICK_DIV−GUARD cycles per unblanked slot.
- Load-to-visible latency: from acceptance, ≤ one frame to boundary, then idx·TICK_DIV+GUARD cycles to digit idx lighting.
- Second load while pending full is stalled (ready=0) until boundary; never overwrites.
- Reset asserted mid-slot: outputs go to reset values immediately (async); pending load discarded.

## Structure
- Shared header `seg7_pkg.vh`: FSM state encodings (GUARD, DRIVE), default DIGITS/TICK_DIV/GUARD, counter-width macro `$clog2(TICK_DIV)`.
- Sub-module `seg7_slot_timer`: slot counter, `in_guard`, `slot_end`, and digit index with wrap; controller holds buffers, handshake and output registers.
- Decoder is not instantiated here; top level connects `seg_mode`/`seg_data` to `bin_7seg_disp`.

## Test plan
(Bench: DIGITS=4, TICK_DIV=8, GUARD=2.)
- Reset release, no load -> `an_n`=4'hF for full frame 32 cycles, `frame_done` pulses at cycle 31, `load_ready`=1.
- Load data 16'h9F30, mode 4'b0000, blank 0 -> next boundary: slot0 `seg_data`=0 cycles 0–7, `an_n`=4'hE cycles 2–7; slot1 `seg_data`=3, `an_n`=4'hD; slot3 `seg_data`=9.
- Mode 4'b0001, nibble0 = 4'hF -> `seg_mode`=1, `seg_data`=4'hF in slot0 (decoder shows −1).
- Two back-to-back loads A then B -> A accepted, `load_ready`=0 until boundary, B accepted one cycle after boundary, A displayed first frame, B the following frame.
- Blank 4'b0100 -> `an_n` stays 4'hF throughout slot2 while `seg_data` still updates.
- Assert `rst_n`=0 at cycle 13 mid-DRIVE -> `an_n`=4'hF same cycle, pending cleared, scanning restarts at slot0 after release.
